// File: rtl/dmem_pkg.sv
// Shared types and helpers for the RV32 data-memory load/store unit:
// funct3 codes, FSM states, byte-lane masks and load extension.
package dmem_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_e;

  // Byte-enable pattern of an access before it is shifted to its lane.
  function automatic logic [3:0] size_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic [2:0] funct3, input logic we);
    if (we) begin
      return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end
    return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3[1:0])
      2'b01:   return offset[0];
      2'b10:   return offset != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] funct3, input logic [31:0] data);
    case (funct3)
      F3_B:    return {{24{data[7]}}, data[7:0]};
      F3_H:    return {{16{data[15]}}, data[15:0]};
      F3_BU:   return {24'h0, data[7:0]};
      F3_HU:   return {16'h0, data[15:0]};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering over a two-word window {hi_word, lo_word}:
// store data/mask shifted into lanes, load data shifted down and extended.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  output logic [63:0] st_data,
  output logic [7:0]  st_mask,
  output logic [31:0] ld_data
);

  logic [63:0] raw;
  logic        unused_raw;

  // Bits [63:32] of data and mask belong to the following word of a split access.
  always_comb begin
    st_mask = {4'b0000, size_mask(funct3)} << offset;
    st_data = {32'h0, wdata} << {offset, 3'b000};
    raw     = {hi_word, lo_word} >> {offset, 3'b000};
    ld_data = load_extend(funct3, raw[31:0]);
  end

  assign unused_raw = ^raw[63:32];

endmodule

// File: rtl/dmem_lsu.sv
// RV32 data memory with byte/half/word loads and stores, one-cycle responses.
// Define DMEM_MISALIGN_SPLIT_EN to service misaligned accesses as two-cycle split accesses.
module dmem_lsu #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);
  import dmem_pkg::*;

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      mem [DEPTH_WORDS];
  state_e           state, state_nxt;

  logic             accept, legal, misaligned, split_go, fault_now;
  logic [IDX_W-1:0] idx;

  logic             sp_we;
  logic [2:0]       sp_funct3;
  logic [1:0]       sp_offset;
  logic [31:0]      sp_wdata, sp_lo_word;
  logic [IDX_W-1:0] sp_idx;

  logic [2:0]       al_funct3;
  logic [1:0]       al_offset;
  logic [31:0]      al_wdata, al_lo, al_hi, al_ld;
  logic [63:0]      al_st_data;
  logic [7:0]       al_st_mask;

  logic             w_en;
  logic [IDX_W-1:0] w_idx;
  logic [3:0]       w_mask;
  logic [31:0]      w_data;

  logic             unused_addr;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // the response is a one-cycle rsp_valid pulse with no backpressure.
  assign req_ready   = (state == ST_IDLE) && !rst;
  assign accept      = req_valid && req_ready;
  assign idx         = req_addr[IDX_W+1:2];
  assign legal       = funct3_legal(req_funct3, req_we);
  assign misaligned  = is_misaligned(req_funct3, req_addr[1:0]);
  assign unused_addr = ^req_addr[31:IDX_W+2];

`ifdef DMEM_MISALIGN_SPLIT_EN
  assign split_go  = accept && legal && misaligned;
  assign fault_now = !legal;
`else
  assign split_go  = 1'b0;
  assign fault_now = !legal || misaligned;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (split_go) state_nxt = ST_SPLIT;
      ST_SPLIT: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // In SPLIT the aligner sees the held request and the word that follows it.
  always_comb begin
    if (state == ST_SPLIT) begin
      al_funct3 = sp_funct3;
      al_offset = sp_offset;
      al_wdata  = sp_wdata;
      al_lo     = sp_lo_word;
      al_hi     = mem[sp_idx];
    end else begin
      al_funct3 = req_funct3;
      al_offset = req_addr[1:0];
      al_wdata  = req_wdata;
      al_lo     = mem[idx];
      al_hi     = 32'h0;
    end
  end

  dmem_lane_align u_align (
    .funct3  (al_funct3),
    .offset  (al_offset),
    .wdata   (al_wdata),
    .lo_word (al_lo),
    .hi_word (al_hi),
    .st_data (al_st_data),
    .st_mask (al_st_mask),
    .ld_data (al_ld)
  );

  always_comb begin
    w_en   = 1'b0;
    w_idx  = idx;
    w_mask = al_st_mask[3:0];
    w_data = al_st_data[31:0];
    if (state == ST_SPLIT) begin
      w_en   = sp_we;
      w_idx  = sp_idx;
      w_mask = al_st_mask[7:4];
      w_data = al_st_data[63:32];
    end else if (accept && req_we && !fault_now) begin
      w_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'h0;
    end else if (w_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_mask[b]) mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'h0;
      rsp_fault  <= 1'b0;
      sp_we      <= 1'b0;
      sp_funct3  <= 3'b000;
      sp_offset  <= 2'b00;
      sp_wdata   <= 32'h0;
      sp_lo_word <= 32'h0;
      sp_idx     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_fault <= 1'b0;
      if (state == ST_SPLIT) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= sp_we ? 32'h0 : al_ld;
      end else if (split_go) begin
        sp_we      <= req_we;
        sp_funct3  <= req_funct3;
        sp_offset  <= req_addr[1:0];
        sp_wdata   <= req_wdata;
        sp_lo_word <= mem[idx];
        sp_idx     <= idx + 1'b1;
      end else if (accept) begin
        rsp_valid <= 1'b1;
        rsp_fault <= fault_now;
        rsp_rdata <= (fault_now || req_we) ? 32'h0 : al_ld;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed vector table, hand-written reset/back-to-back
// sequences, then random traffic against a byte-array reference model.
module tb_dmem_lsu;

  localparam int DEPTH     = 256;
  localparam int MEM_BYTES = DEPTH * 4;
`ifdef DMEM_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;

  dmem_lsu #(.DEPTH_WORDS(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_fault  (rsp_fault)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mem_b [MEM_BYTES];
  logic [32:0] exp_q [$];
  int          due_q [$];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    int          exp_lat;
  } vec_t;

  vec_t vt [$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rd, input logic flt,
                              input int lat);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = rd; v.exp_fault = flt; v.exp_lat = lat;
    return v;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < MEM_BYTES; i++) mem_b[i] = 8'h00;
  endfunction

  // Reference: little-endian byte memory, byte address taken modulo memory size.
  task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] rdata,
                              output logic fault, output int lat);
    int size;
    bit ok;
    int unsigned b;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ok    = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    rdata = 32'h0;
    fault = 1'b0;
    lat   = 1;
    if (!ok || ((addr % size) != 0 && !SPLIT)) begin
      fault = 1'b1;
    end else begin
      if ((addr % size) != 0) lat = 2;
      for (int i = 0; i < size; i++) begin
        b = (addr + 32'(i)) % MEM_BYTES;
        if (we) mem_b[b] = wdata[8*i +: 8];
        else    rdata[8*i +: 8] = mem_b[b];
      end
      if (!we && size < 4 && !f3[2] && rdata[8*size-1]) begin
        for (int k = 8*size; k < 32; k++) rdata[k] = 1'b1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_req(input vec_t v, input string name);
    int  lat;
    bit  got;
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    check({name, "_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= 4 && !got; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (k == 1) check({name, "_busy"}, 32'(req_ready), 32'(v.exp_lat == 1));
      if (rsp_valid) begin
        got = 1'b1;
        lat = k;
        check({name, "_rdata"}, rsp_rdata, v.exp_rdata);
        check({name, "_fault"}, 32'(rsp_fault), 32'(v.exp_fault));
      end
    end
    check({name, "_latency"}, 32'(lat), 32'(v.exp_lat));
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(req_ready), 32'd1);
    model_clear();
  endtask

  // ---------------- test ----------------
  initial begin
    logic        v, we;
    logic [2:0]  f3;
    logic [31:0] a, wd, rd, got_rd;
    logic        flt;
    logic [32:0] e;
    int          lat, ecnt, busy_edge, widx;
    bit          exp_ready;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    apply_reset(3);

    // Directed vectors, memory starts cleared.
    vt.push_back(mk(1, 3'd2, 32'h10,  32'hDEADBEEF, 32'h0,        0, 1));
    vt.push_back(mk(0, 3'd2, 32'h10,  32'h0,        32'hDEADBEEF, 0, 1));
    vt.push_back(mk(1, 3'd0, 32'h13,  32'h12345680, 32'h0,        0, 1));
    vt.push_back(mk(0, 3'd0, 32'h13,  32'h0,        32'hFFFFFF80, 0, 1));
    vt.push_back(mk(0, 3'd4, 32'h13,  32'h0,        32'h00000080, 0, 1));
    vt.push_back(mk(0, 3'd2, 32'h10,  32'h0,        32'h80ADBEEF, 0, 1));
    vt.push_back(mk(0, 3'd1, 32'h12,  32'h0,        32'hFFFF80AD, 0, 1));
    vt.push_back(mk(0, 3'd5, 32'h10,  32'h0,        32'h0000BEEF, 0, 1));
    vt.push_back(mk(0, 3'd3, 32'h0,   32'h0,        32'h0,        1, 1));
    vt.push_back(mk(0, 3'd7, 32'h4,   32'h0,        32'h0,        1, 1));
    vt.push_back(mk(1, 3'd4, 32'h10,  32'h0,        32'h0,        1, 1));
    vt.push_back(mk(1, 3'd3, 32'h10,  32'h0,        32'h0,        1, 1));
    vt.push_back(mk(0, 3'd2, 32'h10,  32'h0,        32'h80ADBEEF, 0, 1));
    vt.push_back(mk(1, 3'd1, 32'h16,  32'h1234A55A, 32'h0,        0, 1));
    vt.push_back(mk(0, 3'd2, 32'h14,  32'h0,        32'hA55A0000, 0, 1));
    vt.push_back(mk(1, 3'd2, 32'h400, 32'hCAFEF00D, 32'h0,        0, 1));
    vt.push_back(mk(0, 3'd2, 32'h0,   32'h0,        32'hCAFEF00D, 0, 1));
    vt.push_back(mk(1, 3'd2, 32'h10,  32'h11223344, 32'h0,        0, 1));
    vt.push_back(mk(1, 3'd2, 32'h14,  32'h55667788, 32'h0,        0, 1));
    vt.push_back(mk(0, 3'd2, 32'h12,  32'h0,  SPLIT ? 32'h77881122 : 32'h0, !SPLIT, SPLIT ? 2 : 1));
    vt.push_back(mk(0, 3'd1, 32'h13,  32'h0,  SPLIT ? 32'hFFFF8811 : 32'h0, !SPLIT, SPLIT ? 2 : 1));
    vt.push_back(mk(1, 3'd2, 32'h3FE, 32'hA1B2C3D4, 32'h0,        !SPLIT, SPLIT ? 2 : 1));
    vt.push_back(mk(0, 3'd2, 32'h0,   32'h0,  SPLIT ? 32'hCAFEA1B2 : 32'hCAFEF00D, 0, 1));
    vt.push_back(mk(0, 3'd2, 32'h3FE, 32'h0,  SPLIT ? 32'hA1B2C3D4 : 32'h0, !SPLIT, SPLIT ? 2 : 1));
    vt.push_back(mk(0, 3'd5, 32'h3FF, 32'h0,  SPLIT ? 32'h0000B2C3 : 32'h0, !SPLIT, SPLIT ? 2 : 1));
    vt.push_back(mk(0, 3'd0, 32'h3FF, 32'h0,  SPLIT ? 32'hFFFFFFC3 : 32'h0, 0, 1));
    vt.push_back(mk(0, 3'd2, 32'h3FC, 32'h0,  SPLIT ? 32'hC3D40000 : 32'h0, 0, 1));
    for (int i = 0; i < vt.size(); i++) do_req(vt[i], $sformatf("vec%0d", i));

    // Store then load of the same word on consecutive cycles.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h30; req_wdata = 32'h0BADF00D;
    @(posedge clk); #1;
    check("b2b_store_valid", 32'(rsp_valid), 32'd1);
    check("b2b_ready", 32'(req_ready), 32'd1);
    req_we = 1'b0; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("b2b_load_valid", 32'(rsp_valid), 32'd1);
    check("b2b_load_rdata", rsp_rdata, 32'h0BADF00D);

    // Reset arriving in the cycle after a misaligned store is accepted.
    do_req(mk(1, 3'd2, 32'h24, 32'h5555AAAA, 32'h0, 0, 1), "pre_rst_sw");
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h22; req_wdata = 32'h11223344;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_first_cycle", 32'(rsp_valid), 32'(!SPLIT));
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rst = 1'b0; #1;
    check("abort_ready", 32'(req_ready), 32'd1);
    model_clear();
    do_req(mk(0, 3'd2, 32'h20, 32'h0, 32'h0, 0, 1), "abort_lw20");
    do_req(mk(0, 3'd2, 32'h24, 32'h0, 32'h0, 0, 1), "abort_lw24");
    do_req(mk(0, 3'd2, 32'h10, 32'h0, 32'h0, 0, 1), "abort_lw10");

    // Random traffic against the byte model, one decision per cycle.
    apply_reset(2);
    ecnt = 0;
    busy_edge = -1;
    for (int c = 0; c < 800; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we)                   f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 == 3'd3) f3 = 3'd5;
      end
      widx = $urandom_range(0, 11);
      if (widx >= 8) widx = DEPTH - 12 + widx;
      a  = ($urandom() & 32'hFFFF_FC00) | 32'(widx << 2) | 32'($urandom_range(0, 3));
      wd = $urandom();
      req_valid = v; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      exp_ready = (ecnt != busy_edge);
      check("rnd_ready", 32'(req_ready), 32'(exp_ready));
      @(posedge clk);
      ecnt++;
      if (v && exp_ready) begin
        model_access(we, f3, a, wd, rd, flt, lat);
        exp_q.push_back({flt, rd});
        due_q.push_back(ecnt + lat - 1);
        if (lat == 2) busy_edge = ecnt;
      end
      #1;
      if (due_q.size() > 0 && due_q[0] == ecnt) begin
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        got_rd = rsp_rdata;
        check("rnd_valid", 32'(rsp_valid), 32'd1);
        check("rnd_rdata", got_rd, e[31:0]);
        check("rnd_fault", 32'(rsp_fault), 32'(e[32]));
      end else begin
        check("rnd_idle", 32'(rsp_valid), 32'd0);
      end
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rnd_drain", 32'(due_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
